// File: rtl/wb_exc_ctrl.sv
// Writeback-stage exception/commit controller: arbitrates exceptions, interrupts, ERTN and
// CSR writes, drives the CSR file strobes, then sequences a flush and a fetch redirect.
module wb_exc_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic [4:0]  ws_ex_vec,
  input  logic        ws_ertn,
  input  logic        ws_csr_we,
  input  logic        ws_csr_xchg,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rj_value,
  input  logic [31:0] ws_rd_value,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic        csr_crmd_ie,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        ws_allowin,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        flush_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  logic       int_pend_q;
  logic [1:0] flush_cnt;
  logic       commit;

  // Exception flags are {adef, ine, sys, brk, ale}; a pending interrupt outranks all of them.
  function automatic logic [5:0] sel_ecode(input logic int_pend, input logic [4:0] ex_vec);
    if (int_pend)       return 6'h00;
    else if (ex_vec[4]) return 6'h08;
    else if (ex_vec[3]) return 6'h0D;
    else if (ex_vec[2]) return 6'h0B;
    else if (ex_vec[1]) return 6'h0C;
    else if (ex_vec[0]) return 6'h09;
    else                return 6'h00;
  endfunction

  assign commit      = ws_valid & (state == IDLE);
  assign ws_allowin  = (state == IDLE);
  assign wb_ex       = commit & (int_pend_q | (|ws_ex_vec));
  assign wb_ecode    = wb_ex ? sel_ecode(int_pend_q, ws_ex_vec) : 6'h00;
  assign wb_esubcode = 9'h000;
  assign wb_pc       = ws_pc;
  assign wb_vaddr    = ws_vaddr;
  assign ertn_flush  = commit & ws_ertn & ~wb_ex;
  assign csr_we      = commit & ws_csr_we & ~wb_ex;
  assign csr_num     = ws_csr_num;
  assign csr_wmask   = ws_csr_xchg ? ws_rj_value : 32'hFFFF_FFFF;
  assign csr_wvalue  = ws_rd_value;

  // Control stage: flush_out and redirect_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      int_pend_q     <= 1'b0;
      flush_cnt      <= 2'd0;
      flush_out      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      int_pend_q <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
      case (state)
        IDLE: begin
          if (wb_ex | ertn_flush) begin
            state       <= FLUSH;
            flush_cnt   <= 2'd0;
            flush_out   <= 1'b1;
            redirect_pc <= wb_ex ? csr_eentry : csr_era;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state          <= REDIRECT;
            flush_out      <= 1'b0;
            redirect_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          flush_out      <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Bench for wb_exc_ctrl: table of commit vectors checked through a scoreboard queue,
// plus hand sequences for reset behaviour and the flush/redirect handshake.
module tb_wb_exc_ctrl;

  localparam int          FC     = 2;
  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc, ws_vaddr;
  logic [4:0]  ws_ex_vec;
  logic        ws_ertn, ws_csr_we, ws_csr_xchg;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value, ws_rd_value;
  logic [12:0] csr_estat_is, csr_ecfg_lie;
  logic        csr_crmd_ie;
  logic [31:0] csr_eentry, csr_era;
  logic        ws_allowin, wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        flush_out, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  wb_exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
    .ws_ex_vec(ws_ex_vec), .ws_ertn(ws_ertn), .ws_csr_we(ws_csr_we),
    .ws_csr_xchg(ws_csr_xchg), .ws_csr_num(ws_csr_num), .ws_rj_value(ws_rj_value),
    .ws_rd_value(ws_rd_value), .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie),
    .csr_crmd_ie(csr_crmd_ie), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .ws_allowin(ws_allowin), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .csr_we(csr_we),
    .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .flush_out(flush_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        int_on;
    logic [4:0]  ex;
    logic        ertn;
    logic        cwe;
    logic        xchg;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rd;
    logic [31:0] pc;
    logic        exp_ex;
    logic [5:0]  exp_ecode;
    logic        exp_ertn;
    logic        exp_we;
    logic [31:0] exp_mask;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t        vecs[15];
  vec_t        sb_q[$];
  logic [31:0] pc_q[$];
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic clear_ws();
    ws_valid = 1'b0; ws_ex_vec = 5'b0; ws_ertn = 1'b0; ws_csr_we = 1'b0;
    ws_csr_xchg = 1'b0; ws_csr_num = 14'h0; ws_rj_value = 32'h0; ws_rd_value = 32'h0;
    ws_pc = 32'h0; ws_vaddr = 32'h0;
  endtask

  // Called just after the commit edge; walks flush, redirect hold and handshake.
  task automatic run_flush(input logic [31:0] exp_pc, input string tag);
    logic [31:0] want;
    pc_q.push_back(exp_pc);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      chk({tag, "_flush_out"}, 32'(flush_out), 32'd1);
      chk({tag, "_flush_rv"}, 32'(redirect_valid), 32'd0);
      chk({tag, "_flush_allowin"}, 32'(ws_allowin), 32'd0);
      chk({tag, "_flush_strobes"}, {29'd0, wb_ex, ertn_flush, csr_we}, 32'd0);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
    end
    redirect_ready = 1'b0;
    ws_valid = 1'b0;
    @(negedge clk);
    want = pc_q.pop_front();
    chk({tag, "_redir_valid"}, 32'(redirect_valid), 32'd1);
    chk({tag, "_redir_flush_off"}, 32'(flush_out), 32'd0);
    chk({tag, "_redir_pc"}, redirect_pc, want);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_redir_hold"}, 32'(redirect_valid), 32'd1);
    chk({tag, "_redir_pc_hold"}, redirect_pc, want);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_rv"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_done_allowin"}, 32'(ws_allowin), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    vec_t  e;
    string tag;
    tag = $sformatf("v%0d", idx);
    clear_ws();
    redirect_ready = 1'b0;
    csr_crmd_ie = v.int_on;
    @(posedge clk); #1;
    ws_ex_vec = v.ex; ws_ertn = v.ertn; ws_csr_we = v.cwe; ws_csr_xchg = v.xchg;
    ws_csr_num = v.num; ws_rj_value = v.rj; ws_rd_value = v.rd;
    ws_pc = v.pc; ws_vaddr = v.pc + 32'h4; ws_valid = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, "_allowin"}, 32'(ws_allowin), 32'd1);
    chk({tag, "_wb_ex"}, 32'(wb_ex), 32'(e.exp_ex));
    chk({tag, "_ecode"}, 32'(wb_ecode), 32'(e.exp_ecode));
    chk({tag, "_esub"}, 32'(wb_esubcode), 32'd0);
    chk({tag, "_ertn"}, 32'(ertn_flush), 32'(e.exp_ertn));
    chk({tag, "_csr_we"}, 32'(csr_we), 32'(e.exp_we));
    chk({tag, "_wmask"}, csr_wmask, e.exp_mask);
    chk({tag, "_wvalue"}, csr_wvalue, e.rd);
    chk({tag, "_num"}, 32'(csr_num), 32'(e.num));
    chk({tag, "_wb_pc"}, wb_pc, e.pc);
    chk({tag, "_vaddr"}, wb_vaddr, e.pc + 32'h4);
    @(posedge clk); #1;
    if (e.exp_ex || e.exp_ertn) begin
      run_flush(e.exp_redir, tag);
    end else begin
      ws_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_no_flush"}, 32'(flush_out), 32'd0);
      chk({tag, "_no_redir"}, 32'(redirect_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0, 5'b00000, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0000, 0, 6'h00, 0, 0, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{0, 5'b00010, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0100, 1, 6'h0C, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[2]  = '{0, 5'b10001, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0104, 1, 6'h08, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[3]  = '{1, 5'b10001, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0108, 1, 6'h00, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[4]  = '{0, 5'b00000, 0, 1, 1, 14'h30, 32'h0000_FFFF, 32'h1234_5678, 32'h1C00_010C, 0, 6'h00, 0, 1, 32'h0000_FFFF, 32'h0};
    vecs[5]  = '{0, 5'b00000, 0, 1, 0, 14'h05, 32'hDEAD_0000, 32'h0000_ABCD, 32'h1C00_0110, 0, 6'h00, 0, 1, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{0, 5'b00000, 1, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0114, 0, 6'h00, 1, 0, 32'hFFFF_FFFF, ERA};
    vecs[7]  = '{0, 5'b00001, 1, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0118, 1, 6'h09, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[8]  = '{0, 5'b01000, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_011C, 1, 6'h0D, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[9]  = '{0, 5'b00100, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0120, 1, 6'h0B, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[10] = '{1, 5'b00000, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0124, 1, 6'h00, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[11] = '{0, 5'b00100, 0, 1, 1, 14'h01, 32'h0000_F0F0, 32'h0000_0005, 32'h1C00_0128, 1, 6'h0B, 0, 0, 32'h0000_F0F0, EENTRY};
    vecs[12] = '{0, 5'b01110, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_012C, 1, 6'h0D, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[13] = '{0, 5'b00110, 0, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0130, 1, 6'h0B, 0, 0, 32'hFFFF_FFFF, EENTRY};
    vecs[14] = '{1, 5'b00000, 1, 0, 0, 14'h00, 32'h0,      32'h0,         32'h1C00_0134, 1, 6'h00, 0, 0, 32'hFFFF_FFFF, EENTRY};

    clear_ws();
    csr_estat_is = 13'h001; csr_ecfg_lie = 13'h001; csr_crmd_ie = 1'b0;
    csr_eentry = EENTRY; csr_era = ERA; redirect_ready = 1'b0;

    // Reset with a plain instruction presented.
    reset = 1'b1;
    ws_valid = 1'b1; ws_pc = 32'h1C00_0000;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_strobes", {27'd0, wb_ex, ertn_flush, csr_we, flush_out, redirect_valid}, 32'd0);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_allowin", 32'(ws_allowin), 32'd1);
    chk("post_rst_flush", 32'(flush_out), 32'd0);

    for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

    // Reset while a redirect is pending and not yet accepted.
    clear_ws();
    csr_crmd_ie = 1'b0;
    @(posedge clk); #1;
    ws_valid = 1'b1; ws_ex_vec = 5'b00010; ws_pc = 32'h1C00_0200;
    @(posedge clk); #1;
    ws_valid = 1'b0;
    repeat (FC) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstredir_pre_valid", 32'(redirect_valid), 32'd1);
    chk("rstredir_pre_pc", redirect_pc, EENTRY);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstredir_valid", 32'(redirect_valid), 32'd0);
    chk("rstredir_allowin", 32'(ws_allowin), 32'd1);
    chk("rstredir_pc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstredir_stays_idle", {30'd0, redirect_valid, flush_out}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
